// File: rtl/shift_sub_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Divide-by-zero and quotient overflow are resolved at the accepting edge without iterating.
module shift_sub_div #(
  parameter int N = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t        state_q;
  logic [N-1:0]  d_q;
  // Partial remainder never exceeds divisor-1 between iterations, so its top bit is always 0
  // and only the low N bits are stored; the N+1-bit width lives in the shifted/trial values.
  logic [N-1:0]  prem_q;
  logic [N-1:0]  qreg_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, dbz_q, ovf_q;
  logic [N-1:0]  quo_q, rem_q;

  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic [N-1:0]  prem_d;
  logic [N-1:0]  qreg_d;

  always_comb begin
    shifted = {prem_q, qreg_q[N-1]};
    trial   = shifted - {1'b0, d_q};
    prem_d  = trial[N] ? shifted[N-1:0] : trial[N-1:0];
    qreg_d  = {qreg_q[N-2:0], ~trial[N]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      prem_q  <= '0;
      qreg_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            d_q <= divisor;
            if (divisor == '0) begin
              dbz_q   <= 1'b1;
              ovf_q   <= 1'b0;
              quo_q   <= '1;
              rem_q   <= dividend[N-1:0];
              done_q  <= 1'b1;
              state_q <= FIN;
            end else if (dividend[2*N-1:N] >= divisor) begin
              dbz_q   <= 1'b0;
              ovf_q   <= 1'b1;
              quo_q   <= '1;
              rem_q   <= dividend[N-1:0];
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              dbz_q   <= 1'b0;
              ovf_q   <= 1'b0;
              prem_q  <= dividend[2*N-1:N];
              qreg_q  <= dividend[N-1:0];
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          prem_q <= prem_d;
          qreg_q <= qreg_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= qreg_d;
            rem_q   <= prem_d;
            state_q <= FIN;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_shift_sub_div.sv
// Directed bench for shift_sub_div: an N=8 instance for hand-computed vectors and an
// N=256 instance for product-built vectors and mid-operation reset.
module tb_shift_sub_div;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start8 = 1'b0;
  logic [15:0]  dividend8 = '0;
  logic [7:0]   divisor8 = '0;
  logic         busy8, done8, dbz8, ovf8;
  logic [7:0]   q8, r8;

  logic         start256 = 1'b0;
  logic [511:0] dividend256 = '0;
  logic [255:0] divisor256 = '0;
  logic         busy256, done256, dbz256, ovf256;
  logic [255:0] q256, r256;

  shift_sub_div #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
    .div_by_zero(dbz8), .overflow(ovf8)
  );

  shift_sub_div #(.N(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .start(start256), .dividend(dividend256), .divisor(divisor256),
    .busy(busy256), .done(done256), .quotient(q256), .remainder(r256),
    .div_by_zero(dbz256), .overflow(ovf256)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Latency counts negedges after the accepting edge; 1 = cycle right after it.
  task automatic run8(input logic [15:0] dd, input logic [7:0] dv, input int pulse_at,
                      output int lat, output int bcnt);
    @(negedge clk);
    dividend8 = dd; divisor8 = dv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) @(negedge clk);
      if (i == pulse_at) begin
        start8 = 1'b1; dividend8 = 16'h0001; divisor8 = 8'h01;
      end else begin
        start8 = 1'b0;
      end
      if (busy8) bcnt++;
      if (done8) begin lat = i; break; end
    end
    start8 = 1'b0;
  endtask

  task automatic run256(input logic [511:0] dd, input logic [255:0] dv, output int lat);
    @(negedge clk);
    dividend256 = dd; divisor256 = dv; start256 = 1'b1;
    @(negedge clk);
    start256 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      if (i > 1) @(negedge clk);
      if (done256) begin lat = i; break; end
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  typedef struct {
    logic [15:0] dd; logic [7:0] dv; logic [7:0] q; logic [7:0] r;
    logic dbz; logic ovf; int lat;
  } vec8_t;

  vec8_t tbl[$];

  initial begin
    int lat, bcnt, seen;
    logic [255:0] x, y, rr;
    logic [511:0] prod;

    tbl.push_back('{16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 9});
    tbl.push_back('{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 9});
    tbl.push_back('{16'h5600, 8'h56, 8'hFF, 8'h00, 1'b0, 1'b1, 1});
    tbl.push_back('{16'hABCD, 8'h00, 8'hFF, 8'hCD, 1'b1, 1'b0, 1});
    tbl.push_back('{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 9});
    tbl.push_back('{16'h0000, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0, 9});
    tbl.push_back('{16'h00C8, 8'h0A, 8'h14, 8'h00, 1'b0, 1'b0, 9});
    tbl.push_back('{16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0, 9});
    tbl.push_back('{16'h0100, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 1});

    repeat (2) @(negedge clk);
    chk("rst busy8", busy8, 0);   chk("rst done8", done8, 0);
    chk("rst q8", q8, 0);         chk("rst r8", r8, 0);
    chk("rst flags8", {dbz8, ovf8}, 0);
    chk("rst q256", q256, 0);     chk("rst busy256", busy256, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run8(tbl[i].dd, tbl[i].dv, 0, lat, bcnt);
      chk($sformatf("lat8[%0d]", i), lat, tbl[i].lat);
      chk($sformatf("busy8[%0d]", i), bcnt, (tbl[i].lat == 9) ? 8 : 0);
      chk($sformatf("q8[%0d]", i), q8, tbl[i].q);
      chk($sformatf("r8[%0d]", i), r8, tbl[i].r);
      chk($sformatf("dbz8[%0d]", i), dbz8, tbl[i].dbz);
      chk($sformatf("ovf8[%0d]", i), ovf8, tbl[i].ovf);
    end

    // Mid-CALC start pulse, then a pulse on the done cycle: both ignored.
    run8(16'h1234, 8'h56, 4, lat, bcnt);
    chk("midcalc lat", lat, 9);
    chk("midcalc q", q8, 8'h36);
    chk("midcalc r", r8, 8'h10);
    start8 = 1'b1; dividend8 = 16'h5600; divisor8 = 8'h56;
    @(negedge clk);
    start8 = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) seen++;
      if (i < 11) @(negedge clk);
    end
    chk("donecyc ignored", seen, 0);
    chk("donecyc q", q8, 8'h36);
    chk("donecyc ovf", ovf8, 0);

    // Start accepted in the cycle right after done.
    run8(16'hFEFF, 8'hFF, 0, lat, bcnt);
    @(negedge clk);
    chk("idle before", busy8, 0);
    start8 = 1'b1; dividend8 = 16'h00C8; divisor8 = 8'h0A;
    @(negedge clk);
    start8 = 1'b0;
    chk("next accepted busy", busy8, 1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if (done8) begin lat = i; break; end
    end
    chk("next lat", lat, 9);
    chk("next q", q8, 8'h14);

    // N=256: dividend = X*Y + R with R < Y guarantees no overflow and exact results.
    for (int v = 0; v < 200; v++) begin
      x = rand256();
      y = rand256() >> $urandom_range(0, 255);
      if (y == '0) y = 256'd1;
      rr = rand256() % y;
      prod = {256'b0, x} * {256'b0, y} + {256'b0, rr};
      run256(prod, y, lat);
      chk($sformatf("lat256[%0d]", v), lat, 257);
      chk($sformatf("q256[%0d]", v), q256, x);
      chk($sformatf("r256[%0d]", v), r256, rr);
      chk($sformatf("flags256[%0d]", v), {dbz256, ovf256}, 0);
    end

    // Reset at iteration ~100 aborts the operation.
    @(negedge clk);
    dividend256 = {256'h1, 256'h0}; divisor256 = '1; start256 = 1'b1;
    @(negedge clk);
    start256 = 1'b0;
    repeat (99) @(negedge clk);
    chk("pre-abort busy", busy256, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort busy", busy256, 0);  chk("abort done", done256, 0);
    chk("abort q", q256, 0);        chk("abort r", r256, 0);
    chk("abort flags", {dbz256, ovf256}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done256) seen++;
    end
    chk("abort no done", seen, 0);

    x = {128'hDEADBEEF_01234567_89ABCDEF_F00DCAFE, 128'h1};
    y = {64'h1, 192'h0};
    rr = 256'h12345;
    prod = {256'b0, x} * {256'b0, y} + {256'b0, rr};
    run256(prod, y, lat);
    chk("post-rst lat", lat, 257);
    chk("post-rst q", q256, x);
    chk("post-rst r", r256, rr);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
